alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle initiator that drives the 32-bit combinational ALU's operand, opcode and result/branch-condition interface. It accepts operation requests over a valid/ready handshake and maps each to ALU opcodes. Variable shifts are built by iterating the ALU's shift-by-one operations, with the result fed back each cycle. The result and branch decision are returned over a second valid/ready handshake; the block sits between the execute-stage control and the ALU.

## Interface
- DATA_W, 32, operand/result width; matches the ALU.
- SHAMT_W, 5, shift-amount width; taken from req_b[SHAMT_W-1:0].
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  sequencer opcode (package constants).
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B, or shift amount.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_result  out  DATA_W  operation result; 0 for compares and illegal ops.
- resp_taken  out  1  compare outcome; 0 for non-compares.
- alu_in_1  out  DATA_W  ALU operand 1.
- alu_in_2  out  DATA_W  ALU operand 2.
- alu_op  out  4  ALU opcode.
- alu_result  in  DATA_W  ALU result, combinational.
- alu_bcond  in  1  ALU branch condition, combinational.

## Operation
- Sequencer opcodes:
  - ADD=0 maps to ALU 0000.
  - SUB=1 maps to 0001.
  - AND=2 maps to 0100.
  - OR=3 maps to 0101.
  - XOR=4 maps to 1000.
  - SLL=5 maps to 1010 (shift left by 1).
  - SRL=6 maps to 1011 (logical right by 1).
  - SRA=7 maps to 1101 (arithmetic right by 1).
  - BEQ=8 maps to 0000; bcond means equal.
  - BNE=9 maps to 1010; bcond means not equal.
  - BLTU=10 maps to 1000; bcond means unsigned less-than.
  - BGEU=11 maps to 1011; bcond means unsigned greater-or-equal.
  - NEG=12 maps to 1110.
  - 13–15 are illegal and map to 1111; the response is result 0, taken 0.
- States: IDLE, EXEC, RESP.
  - IDLE → EXEC on req_valid & req_ready.
  - EXEC → RESP when the final iteration completes.
  - RESP → IDLE on resp_ready.
  - reset forces IDLE from any state.
- req_op, req_a and req_b are registered at acceptance; later changes to them are ignored.
- Non-shift ops: exactly one EXEC cycle, with alu_in_1 = A and alu_in_2 = B. At the end of that cycle, alu_result is captured into resp_result and alu_bcond into resp_taken, subject to the opcode rules above.
- Shift ops:
  - A work register loads A and a counter loads shamt.
  - Each EXEC cycle drives alu_in_1 = work and alu_in_2 = 0, then work <= alu_result and counter decrements.
  - The last iteration is the one where counter == 1 at the clock edge.
  - shamt = 0: one EXEC cycle with ALU op 0010 (pass), so the result equals A.
- Outside EXEC, the ALU is driven with alu_op = 1111 and alu_in_1 = alu_in_2 = 0.
- resp_result and resp_taken stay stable while resp_valid & !resp_ready.
- No new request is accepted until the response handshake completes.

## Timing
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0.
  - resp_result=0, resp_taken=0.
  - alu_op=1111, alu_in_1=0, alu_in_2=0.
  - Work register and counter 0.
- Acceptance edge is E0. EXEC occupies N cycles, where N = 1 for non-shifts and N = max(shamt,1) for shifts.
- resp_valid rises in the cycle after the last EXEC cycle, i.e. N+1 cycles after E0.
- The earliest next acceptance is the cycle after the response handshake, which is when req_ready returns to 1.
- Reset asserted in any cycle: the next cycle is IDLE with reset values, and any in-flight op is discarded with no response.
- req_valid during EXEC or RESP is ignored, since req_ready=0.

## Structure
- Package alu_seq_pkg holds:
  - the sequencer opcode constants;
  - the ALU opcode constants (ALU_ADD through ALU_ZERO);
  - the state enum.
- One combinational sub-module, alu_seq_decode, maps req_op to:
  - the ALU opcode;
  - the is_shift, is_cmp and is_illegal flags.
- The FSM, counter, work register and response registers live in the top module.

## Test plan
- ADD, a=5, b=7 → alu_op=0000 in the single EXEC cycle; resp_valid 2 cycles after E0 with result 12, taken 0.
- SLL, a=1, b=4 → four EXEC cycles with alu_op=1010, result 16, resp_valid 5 cycles after E0. SLL a=0xDEADBEEF, b=0 → one cycle with alu_op=0010, result 0xDEADBEEF.
- SRA, a=0x80000000, b=31 → result 0xFFFFFFFF after 31 EXEC cycles. SRL with the same inputs → result 0x00000001.
- BLTU, a=3, b=5 → taken 1, result 0. BGEU with the same inputs → taken 0. BEQ 9,9 → taken 1. BNE 9,9 → taken 0. Opcode 14 → result 0, taken 0.
- resp_ready held low for 3 cycles after resp_valid → outputs stable and req_ready=0 throughout. A new req_valid during that time is not accepted; it is accepted the cycle after resp_ready rises.
- SLL, b=20, with reset asserted during the 10th EXEC cycle → the next cycle is IDLE, req_ready=1, resp_valid=0, alu_op=1111, and no response is ever produced.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: sequencer opcodes,
// ALU opcodes and the sequencer FSM state type.
package alu_seq_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_BLTU = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;
  localparam logic [3:0] OP_NEG  = 4'd12;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_NEG  = 4'b1110;
  localparam logic [3:0] ALU_ZERO = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Maps a sequencer opcode to its ALU opcode and classification flags.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_op,
  output logic       is_shift,
  output logic       is_cmp,
  output logic       is_illegal
);

  always_comb begin
    alu_op     = ALU_ZERO;
    is_shift   = 1'b0;
    is_cmp     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_SLL:  begin alu_op = ALU_SLL; is_shift = 1'b1; end
      OP_SRL:  begin alu_op = ALU_SRL; is_shift = 1'b1; end
      OP_SRA:  begin alu_op = ALU_SRA; is_shift = 1'b1; end
      // The ALU reports each branch condition under a specific opcode
      OP_BEQ:  begin alu_op = ALU_ADD; is_cmp = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SLL; is_cmp = 1'b1; end
      OP_BLTU: begin alu_op = ALU_XOR; is_cmp = 1'b1; end
      OP_BGEU: begin alu_op = ALU_SRL; is_cmp = 1'b1; end
      OP_NEG:  alu_op = ALU_NEG;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator for the combinational ALU: accepts requests, iterates
// single-bit shifts through the ALU and returns result / branch decision.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_taken,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_bcond
);

  state_t              state, state_next;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   work_q;
  logic [DATA_W-1:0]   b_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [3:0]          dec_alu_op;
  logic                is_shift, is_cmp, is_illegal;
  logic                last_iter;

  alu_seq_decode u_decode (
    .op         (op_q),
    .alu_op     (dec_alu_op),
    .is_shift   (is_shift),
    .is_cmp     (is_cmp),
    .is_illegal (is_illegal)
  );

  // A zero shift amount still takes one pass cycle, so 0 and 1 both end EXEC
  assign last_iter  = !is_shift || (cnt_q < SHAMT_W'(2));
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = ALU_ZERO;
    alu_in_1   = '0;
    alu_in_2   = '0;
    case (state)
      ST_IDLE: if (req_valid) state_next = ST_EXEC;
      ST_EXEC: begin
        alu_op   = (is_shift && cnt_q == '0) ? ALU_PASS : dec_alu_op;
        alu_in_1 = work_q;
        alu_in_2 = is_shift ? '0 : b_q;
        if (last_iter) state_next = ST_RESP;
      end
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      work_q      <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      resp_result <= '0;
      resp_taken  <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        op_q   <= req_op;
        work_q <= req_a;
        b_q    <= req_b;
        cnt_q  <= req_b[SHAMT_W-1:0];
      end
      if (state == ST_EXEC) begin
        if (is_shift) begin
          work_q <= alu_result;
          if (cnt_q != '0) cnt_q <= cnt_q - SHAMT_W'(1);
        end
        if (last_iter) begin
          resp_result <= (is_cmp || is_illegal) ? '0 : alu_result;
          resp_taken  <= is_cmp ? alu_bcond : 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer, with a behavioural ALU
// attached and an operation-level reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_taken;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_bcond;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_taken  (resp_taken),
    .alu_in_1    (alu_in_1),
    .alu_in_2    (alu_in_2),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_bcond   (alu_bcond)
  );

  // Behavioural 32-bit ALU that the sequencer drives
  always_comb begin
    alu_result = 32'd0;
    alu_bcond  = 1'b0;
    case (alu_op)
      4'b0000: begin alu_result = alu_in_1 + alu_in_2; alu_bcond = (alu_in_1 == alu_in_2); end
      4'b0001: alu_result = alu_in_1 - alu_in_2;
      4'b0010: alu_result = alu_in_1;
      4'b0100: alu_result = alu_in_1 & alu_in_2;
      4'b0101: alu_result = alu_in_1 | alu_in_2;
      4'b1000: begin alu_result = alu_in_1 ^ alu_in_2; alu_bcond = (alu_in_1 < alu_in_2); end
      4'b1010: begin alu_result = alu_in_1 << 1; alu_bcond = (alu_in_1 != alu_in_2); end
      4'b1011: begin alu_result = alu_in_1 >> 1; alu_bcond = (alu_in_1 >= alu_in_2); end
      4'b1101: alu_result = 32'($signed(alu_in_1) >>> 1);
      4'b1110: alu_result = 32'd0 - alu_in_1;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: result, taken, EXEC length and first ALU opcode
  function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic t, output int n,
                                   output logic [3:0] aop);
    int sh;
    logic signed [31:0] sa;
    sh  = int'(b[4:0]);
    sa  = a;
    r   = 32'd0;
    t   = 1'b0;
    n   = 1;
    aop = 4'b1111;
    case (op)
      4'd0:  begin r = a + b; aop = 4'b0000; end
      4'd1:  begin r = a - b; aop = 4'b0001; end
      4'd2:  begin r = a & b; aop = 4'b0100; end
      4'd3:  begin r = a | b; aop = 4'b0101; end
      4'd4:  begin r = a ^ b; aop = 4'b1000; end
      4'd5:  begin r = a << sh; n = (sh == 0) ? 1 : sh; aop = (sh == 0) ? 4'b0010 : 4'b1010; end
      4'd6:  begin r = a >> sh; n = (sh == 0) ? 1 : sh; aop = (sh == 0) ? 4'b0010 : 4'b1011; end
      4'd7:  begin r = 32'(sa >>> sh); n = (sh == 0) ? 1 : sh; aop = (sh == 0) ? 4'b0010 : 4'b1101; end
      4'd8:  begin t = (a == b); aop = 4'b0000; end
      4'd9:  begin t = (a != b); aop = 4'b1010; end
      4'd10: begin t = (a < b);  aop = 4'b1000; end
      4'd11: begin t = (a >= b); aop = 4'b1011; end
      4'd12: begin r = 32'd0 - a; aop = 4'b1110; end
      default: ;
    endcase
  endfunction

  // One full transaction; called #1 after a rising edge with the DUT idle
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold);
    logic [31:0] exp_r;
    logic        exp_t;
    int          n;
    logic [3:0]  exp_aop;
    int          cyc;
    refModel(op, a, b, exp_r, exp_t, n, exp_aop);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    cyc = 1;
    checkOutput("alu_op_exec", 32'(alu_op), 32'(exp_aop));
    checkOutput("alu_in_1_exec", alu_in_1, a);
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    while (!resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("resp_latency", 32'(cyc), 32'(n + 1));
    if (!resp_valid) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      return;
    end
    checkOutput("resp_result", resp_result, exp_r);
    checkOutput("resp_taken", 32'(resp_taken), 32'(exp_t));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = 4'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_result", resp_result, exp_r);
      checkOutput("hold_taken", 32'(resp_taken), 32'(exp_t));
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    checkOutput("post_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] rop;
    int         seen_resp;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_result", resp_result, 32'd0);
    checkOutput("rst_resp_taken", 32'(resp_taken), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'hF);
    checkOutput("rst_alu_in_1", alu_in_1, 32'd0);
    checkOutput("rst_alu_in_2", alu_in_2, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(4'd0,  32'd5,          32'd7,  0);
    applyStimulus(4'd5,  32'd1,          32'd4,  0);
    applyStimulus(4'd5,  32'hDEADBEEF,   32'd0,  0);
    applyStimulus(4'd7,  32'h80000000,   32'd31, 0);
    applyStimulus(4'd6,  32'h80000000,   32'd31, 0);
    applyStimulus(4'd10, 32'd3,          32'd5,  0);
    applyStimulus(4'd11, 32'd3,          32'd5,  0);
    applyStimulus(4'd8,  32'd9,          32'd9,  0);
    applyStimulus(4'd9,  32'd9,          32'd9,  0);
    applyStimulus(4'd14, 32'h12345678,   32'h9,  0);
    applyStimulus(4'd0,  32'hFFFFFFFF,   32'd2,  3);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      applyStimulus(rop, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // Reset during the 10th EXEC cycle of a 20-step shift discards the op
    req_op    = 4'd5;
    req_a     = 32'd1;
    req_b     = 32'd20;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checkOutput("mid_shift_alu_op", 32'(alu_op), 32'hA);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_alu_op", 32'(alu_op), 32'hF);
    checkOutput("abort_alu_in_1", alu_in_1, 32'd0);
    seen_resp = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (resp_valid) seen_resp++;
    end
    checkOutput("abort_no_resp", 32'(seen_resp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
